// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA timing defaults, derived totals and coordinate helpers
package vga_timing_pkg;

  localparam int COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;

  // 640x480@60 defaults
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL_DEF      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
  localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

  // Centred coordinate: plain 10-bit wrap-around subtraction, no saturation
  function automatic coord_t centre(input coord_t cnt, input int active);
    return cnt - coord_t'(active / 2);
  endfunction

endpackage

// File: rtl/vga_coord_gen_if.sv
// rtl/vga_coord_gen_if.sv - video timing/coordinate bundle driven by vga_coord_gen
interface vga_coord_gen_if;
  import vga_timing_pkg::*;

  logic       pix_tick;
  coord_t     x_pos;
  coord_t     y_pos;
  logic       hsync;
  logic       vsync;
  logic       de;
  logic       frame_start;
  logic [7:0] frame_cnt;

  modport master (
    output pix_tick, x_pos, y_pos, hsync, vsync, de, frame_start, frame_cnt
  );

  modport slave (
    input pix_tick, x_pos, y_pos, hsync, vsync, de, frame_start, frame_cnt
  );

endinterface

// File: rtl/timing_axis.sv
// rtl/timing_axis.sv - one mod-N timing axis: counter, wrap strobe, sync/active/centred decode
module timing_axis
  import vga_timing_pkg::*;
#(
  parameter int TOTAL      = H_TOTAL_DEF,
  parameter int ACTIVE     = H_ACTIVE_DEF,
  parameter int SYNC_START = H_SYNC_START_DEF,
  parameter int SYNC_END   = H_SYNC_END_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   adv,
  output logic   wrap,
  output logic   active_nxt,
  output logic   sync_n,
  output coord_t pos
);

  localparam coord_t LAST = coord_t'(TOTAL - 1);
  localparam coord_t ACT  = coord_t'(ACTIVE);
  localparam coord_t SS   = coord_t'(SYNC_START);
  localparam coord_t SE   = coord_t'(SYNC_END);

  coord_t count;
  coord_t count_nxt;

  // Next count and wrap strobe; decode is taken from the next value so outputs track the counter with no lag
  always_comb begin
    wrap       = adv && (count == LAST);
    count_nxt  = count;
    if (adv) begin
      count_nxt = wrap ? '0 : count + coord_t'(1);
    end
    active_nxt = (count_nxt < ACT);
  end

  // Counter plus registered sync and centred coordinate
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      sync_n <= 1'b1;
      pos    <= centre('0, ACTIVE);
    end else begin
      count  <= count_nxt;
      sync_n <= !((count_nxt >= SS) && (count_nxt < SE));
      pos    <= centre(count_nxt, ACTIVE);
    end
  end

endmodule

// File: rtl/vga_coord_gen.sv
// rtl/vga_coord_gen.sv - VGA raster timing with centred x/y coordinates and frame counter
module vga_coord_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  vga_coord_gen_if.master  vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic       phase;
  logic       h_wrap;
  logic       v_wrap;
  logic       h_act_nxt;
  logic       v_act_nxt;
  logic       h_sync_n;
  logic       v_sync_n;
  coord_t     h_pos;
  coord_t     v_pos;
  logic       de_q;
  logic       frame_start_q;
  logic [7:0] frame_cnt_q;

  // Pixel phase: one tick every second clk, lining up with the 2-cycle x/y radius multiplexing
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= 1'b0;
    end else begin
      phase <= ~phase;
    end
  end

  timing_axis #(
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_END   (H_ACTIVE + H_FP + H_SYNC)
  ) u_h_axis (
    .clk        (clk),
    .rst        (rst),
    .adv        (phase),
    .wrap       (h_wrap),
    .active_nxt (h_act_nxt),
    .sync_n     (h_sync_n),
    .pos        (h_pos)
  );

  timing_axis #(
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_END   (V_ACTIVE + V_FP + V_SYNC)
  ) u_v_axis (
    .clk        (clk),
    .rst        (rst),
    .adv        (h_wrap),
    .wrap       (v_wrap),
    .active_nxt (v_act_nxt),
    .sync_n     (v_sync_n),
    .pos        (v_pos)
  );

  // Display enable, frame-start pulse and completed-frame count; v_wrap only fires on the last pixel of the frame
  always_ff @(posedge clk) begin
    if (rst) begin
      de_q          <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= 8'd0;
    end else begin
      de_q          <= h_act_nxt & v_act_nxt;
      frame_start_q <= v_wrap;
      if (v_wrap) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end

  assign vid.pix_tick    = phase;
  assign vid.x_pos       = h_pos;
  assign vid.y_pos       = v_pos;
  assign vid.hsync       = h_sync_n;
  assign vid.vsync       = v_sync_n;
  assign vid.de          = de_q;
  assign vid.frame_start = frame_start_q;
  assign vid.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_coord_gen.sv
// tb/tb_vga_coord_gen.sv - directed checks of vga_coord_gen at default and shrunken timing
module tb_vga_coord_gen;
  import vga_timing_pkg::*;

  logic clk = 1'b0;
  logic rst_d;
  logic rst_s;

  always #5 clk = ~clk;

  vga_coord_gen_if vd();
  vga_coord_gen_if vs();

  vga_coord_gen dut_d (
    .clk (clk),
    .rst (rst_d),
    .vid (vd)
  );

  // Small raster: 8 px x 7 lines, hsync at h 5..6, vsync at v 5, 112 clk per frame
  vga_coord_gen #(
    .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1)
  ) dut_s (
    .clk (clk),
    .rst (rst_s),
    .vid (vs)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hs_lo, de_hi, trk, first_hs, p, h, v;
    int fs, vs_lo, de_s, hs_s;

    rst_d = 1'b1;
    rst_s = 1'b1;
    step();
    step();

    check("rst_pix_tick", 32'(vd.pix_tick), 0);
    check("rst_x", 32'(vd.x_pos), 32'h2C0);
    check("rst_y", 32'(vd.y_pos), 32'h310);
    check("rst_hsync", 32'(vd.hsync), 1);
    check("rst_vsync", 32'(vd.vsync), 1);
    check("rst_de", 32'(vd.de), 0);
    check("rst_frame_start", 32'(vd.frame_start), 0);
    check("rst_frame_cnt", 32'(vd.frame_cnt), 0);
    check("rst_small_x", 32'(vs.x_pos), 32'h3FE);

    rst_d = 1'b0;
    hs_lo = 0; de_hi = 0; trk = 0; first_hs = -1;
    for (int k = 1; k <= 3200; k++) begin
      step();
      p = k / 2;
      h = p % 800;
      v = p / 800;
      if (vd.x_pos !== 10'(h - 320)) trk++;
      if (vd.y_pos !== 10'(v - 240)) trk++;
      if (k <= 3) check($sformatf("pix_tick_k%0d", k), 32'(vd.pix_tick), 32'(k % 2));
      if (k == 1) check("x_first_tick", 32'(vd.x_pos), 32'h2C0);
      if (k == 2) check("x_after_adv", 32'(vd.x_pos), 32'h2C1);
      if (k >= 1600 && k <= 3199) begin
        if (!vd.hsync) begin
          hs_lo++;
          if (first_hs < 0) first_hs = h;
        end
        if (vd.de) de_hi++;
      end
      if (k == 1599) check("y_line0_end", 32'(vd.y_pos), 32'h310);
      if (k == 1600) check("y_line1_start", 32'(vd.y_pos), 32'h311);
      if (k == 2238) check("x_h319", 32'(vd.x_pos), 32'h3FF);
      if (k == 2240) check("x_h320", 32'(vd.x_pos), 32'h000);
      if (k == 3199) check("x_h799", 32'(vd.x_pos), 32'h1DF);
    end
    check("hsync_low_clks", 32'(hs_lo), 192);
    check("hsync_first_h", 32'(first_hs), 656);
    check("de_high_clks", 32'(de_hi), 1280);
    check("xy_track_errs", 32'(trk), 0);

    for (int k = 3201; k <= 4000; k++) step();
    check("x_h400", 32'(vd.x_pos), 32'h050);
    rst_d = 1'b1;
    step();
    rst_d = 1'b0;
    check("midrst_x", 32'(vd.x_pos), 32'h2C0);
    check("midrst_y", 32'(vd.y_pos), 32'h310);
    check("midrst_pix_tick", 32'(vd.pix_tick), 0);
    check("midrst_de", 32'(vd.de), 0);
    check("midrst_hsync", 32'(vd.hsync), 1);
    check("midrst_frame_cnt", 32'(vd.frame_cnt), 0);
    step();
    check("rel_clk1_tick", 32'(vd.pix_tick), 1);
    check("rel_clk1_x", 32'(vd.x_pos), 32'h2C0);
    step();
    check("rel_clk2_tick", 32'(vd.pix_tick), 0);
    check("rel_clk2_x", 32'(vd.x_pos), 32'h2C1);

    rst_s = 1'b0;
    fs = 0; vs_lo = 0; de_s = 0; hs_s = 0;
    for (int k = 1; k <= 28672; k++) begin
      step();
      if (vs.frame_start) fs++;
      if (k >= 112 && k <= 223) begin
        if (!vs.vsync) vs_lo++;
        if (!vs.hsync) hs_s++;
        if (vs.de) de_s++;
      end
      if (k == 10) check("s_hsync_h5", 32'(vs.hsync), 0);
      if (k == 14) check("s_x_h7", 32'(vs.x_pos), 32'h005);
      if (k == 36) begin
        check("s_x_centre", 32'(vs.x_pos), 0);
        check("s_y_centre", 32'(vs.y_pos), 0);
      end
      if (k == 111) begin
        check("s_fc_before_wrap", 32'(vs.frame_cnt), 0);
        check("s_fs_before_wrap", 32'(vs.frame_start), 0);
      end
      if (k == 112) begin
        check("s_fc_after_wrap", 32'(vs.frame_cnt), 1);
        check("s_fs_pulse", 32'(vs.frame_start), 1);
        check("s_wrap_x", 32'(vs.x_pos), 32'h3FE);
        check("s_wrap_y", 32'(vs.y_pos), 32'h3FE);
      end
      if (k == 113) check("s_fs_one_clk", 32'(vs.frame_start), 0);
      if (k == 28560) check("s_fc_255", 32'(vs.frame_cnt), 255);
      if (k == 28672) check("s_fc_wrap0", 32'(vs.frame_cnt), 0);
    end
    check("s_frame_starts", 32'(fs), 256);
    check("s_vsync_low_clks", 32'(vs_lo), 16);
    check("s_hsync_low_clks", 32'(hs_s), 28);
    check("s_de_high_clks", 32'(de_s), 32);

    for (int k = 28673; k <= 28724; k++) step();
    check("s_y_v3", 32'(vs.y_pos), 32'h001);
    rst_s = 1'b1;
    step();
    rst_s = 1'b0;
    check("s_midrst_fc", 32'(vs.frame_cnt), 0);
    check("s_midrst_x", 32'(vs.x_pos), 32'h3FE);
    check("s_midrst_y", 32'(vs.y_pos), 32'h3FE);
    check("s_midrst_de", 32'(vs.de), 0);
    check("s_midrst_vsync", 32'(vs.vsync), 1);
    for (int k = 1; k <= 112; k++) begin
      step();
      if (k == 2) check("s_rel_x", 32'(vs.x_pos), 32'h3FF);
      if (k == 111) check("s_rel_fc_hold", 32'(vs.frame_cnt), 0);
      if (k == 112) check("s_rel_fc_inc", 32'(vs.frame_cnt), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
